// File: rtl/fir_decimator_if.sv
// Valid/ready bundle between the FIR stage, the decimator and its consumer.
// The slave side is the decimator; the master side is whoever drives samples
// and drains results.
interface fir_decimator_if #(
    parameter int IN_W  = 10,
    parameter int DEPTH = 4
) ();
    localparam int LVL_W = $clog2(DEPTH + 1);

    // Sample input (always accepted, no ready)
    logic             in_valid;
    logic [IN_W-1:0]  in_data;

    // Result output with backpressure
    logic             out_valid;
    logic             out_ready;
    logic [IN_W-1:0]  out_data;

    // Status and control
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic             clr_ovf;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        input  clr_ovf,
        output out_valid,
        output out_data,
        output level,
        output overflow
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        output clr_ovf,
        input  out_valid,
        input  out_data,
        input  level,
        input  overflow
    );
endinterface

// File: rtl/fir_decimator.sv
// Block-average decimator for the FIR output stream.
// Every 2^LOG2N valid samples are summed and averaged with round-half-up; the
// result is pushed into a small FIFO presented on a valid/ready port. A result
// that finds the FIFO full (and no pop in the same cycle) is dropped and a
// sticky overflow flag is raised.
module fir_decimator #(
    parameter int IN_W  = 10,
    parameter int LOG2N = 2,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    fir_decimator_if.slave bus
);
    localparam int N     = 1 << LOG2N;
    localparam int ACC_W = IN_W + LOG2N;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    // Last sample index of a block, rounding bias and full-FIFO occupancy
    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);
    localparam logic [ACC_W-1:0] HALF     = ACC_W'(N / 2);
    localparam logic [LVL_W-1:0] FULL     = LVL_W'(DEPTH);

    // Accumulation state
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LOG2N-1:0] cnt_q, cnt_d;

    // FIFO state
    logic [IN_W-1:0]  mem_q [DEPTH];
    logic [IN_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;

    // Per-cycle decisions
    logic             block_done;
    logic [ACC_W-1:0] block_sum;
    logic [IN_W-1:0]  result;
    logic             pop;
    logic             push;
    logic             drop;

    // Accumulate valid samples and form the rounded average on the last one
    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        block_done = 1'b0;
        // The sum plus the half-LSB bias tops out at N*(2^IN_W-1)+N/2, which
        // is below N*2^IN_W, so ACC_W bits never wrap and the shifted result
        // always fits IN_W bits without saturation.
        block_sum  = acc_q + ACC_W'(bus.in_data);
        result     = IN_W'((block_sum + HALF) >> LOG2N);

        if (bus.in_valid) begin
            if (cnt_q == CNT_LAST) begin
                block_done = 1'b1;
                acc_d      = '0;
                cnt_d      = '0;
            end else begin
                acc_d = block_sum;
                cnt_d = cnt_q + LOG2N'(1);
            end
        end
    end

    // FIFO control: pop on handshake, push on block completion, drop if full
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;

        pop  = (level_q != '0) && bus.out_ready;
        // A pop in the same cycle frees the slot the push needs, so a full
        // FIFO still takes the result: the head advances while the tail
        // overwrites the slot being read out this cycle.
        push = block_done && ((level_q != FULL) || pop);
        drop = block_done && !push;

        if (push) begin
            mem_d[wr_ptr_q] = result;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Sticky overflow: a drop takes priority over a clear in the same cycle
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            // NOTE: the storage is reset as well because out_data reads the
            // head slot directly and must show 0 while the FIFO is empty after
            // reset; this keeps the memory in flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

    // Outputs come from registers and storage only; out_ready never reaches
    // them combinationally.
    assign bus.out_valid = (level_q != '0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.level     = level_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Self-checking bench for fir_decimator: directed scenarios from the block's
// behaviour plus a randomized run against a queue-based reference model.
module tb_fir_decimator;
    localparam int IN_W  = 10;
    localparam int LOG2N = 2;
    localparam int DEPTH = 4;
    localparam int N     = 1 << LOG2N;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_decimator_if #(.IN_W(IN_W), .DEPTH(DEPTH)) bus ();

    fir_decimator #(.IN_W(IN_W), .LOG2N(LOG2N), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: samples of the block in progress, FIFO contents, flag
    int blk[$];
    int fifo[$];
    bit m_ovf;

    task automatic model_reset();
        blk.delete();
        fifo.delete();
        m_ovf = 1'b0;
    endtask

    // Apply one clock edge worth of behaviour to the model
    task automatic model_step(input bit v, input int d, input bit rdy, input bit clr);
        bit popped;
        bit have_res;
        bit dropped;
        int res;
        int s;
        popped   = (fifo.size() != 0) && rdy;
        have_res = 1'b0;
        dropped  = 1'b0;
        res      = 0;
        if (popped) void'(fifo.pop_front());
        if (v) begin
            blk.push_back(d);
            if (blk.size() == N) begin
                s = 0;
                foreach (blk[k]) s += blk[k];
                res      = (s + N / 2) / N;
                have_res = 1'b1;
                blk.delete();
            end
        end
        if (have_res) begin
            if (fifo.size() < DEPTH) fifo.push_back(res);
            else dropped = 1'b1;
        end
        if (dropped) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    // Drive one cycle of inputs, advance model at the edge, settle 1 time unit
    task automatic cycle(input bit v, input int d, input bit rdy, input bit clr);
        bus.in_valid  = v;
        bus.in_data   = IN_W'(d);
        bus.out_ready = rdy;
        bus.clr_ovf   = clr;
        @(posedge clk);
        model_step(v, d, rdy, clr);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.out_data !== '0) begin miscompares++; $display("FAIL reset_data: got %0d want 0", bus.out_data); end
        vectors++; if (bus.level !== '0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", bus.level); end
        vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, i, 1'b1, 1'b0);
            if (i < 4) begin
                vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid s%0d: got %b want 0", i, bus.out_valid); end
            end
        end
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %b want 1", bus.out_valid); end
        vectors++; if (bus.out_data !== 10'd3) begin miscompares++; $display("FAIL basic_data: got %0d want 3", bus.out_data); end
        vectors++; if (bus.level !== 3'd1) begin miscompares++; $display("FAIL basic_level: got %0d want 1", bus.level); end
        cycle(1'b0, 0, 1'b1, 1'b0);
        vectors++; if (bus.level !== 3'd0) begin miscompares++; $display("FAIL basic_level_after: got %0d want 0", bus.level); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_after: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_rounding();
        int pats [3][4] = '{'{1023, 1023, 1023, 1023}, '{0, 0, 0, 2}, '{0, 0, 0, 1}};
        int want [3]    = '{1023, 1, 0};
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int s = 0; s < 4; s++) cycle(1'b1, pats[p][s], 1'b0, 1'b0);
            vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL round_valid p%0d: got %b want 1", p, bus.out_valid); end
            vectors++; if (bus.out_data !== IN_W'(want[p])) begin miscompares++; $display("FAIL round_data p%0d: got %0d want %0d", p, bus.out_data, want[p]); end
            cycle(1'b0, 0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            // Junk on idle cycles must not enter the sum
            cycle(k % 2 == 0, (k % 2 == 0) ? 4 : int'($urandom_range(1, 1023)), 1'b1, 1'b0);
            if (k < 6) begin
                vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL gaps_early_valid k%0d: got %b want 0", k, bus.out_valid); end
            end
        end
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL gaps_valid: got %b want 1", bus.out_valid); end
        vectors++; if (bus.out_data !== 10'd4) begin miscompares++; $display("FAIL gaps_data: got %0d want 4", bus.out_data); end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 0, 1'b1, 1'b0);
            vectors++; if (bus.level !== 3'd0) begin miscompares++; $display("FAIL gaps_single k%0d: level got %0d want 0", k, bus.level); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int b = 0; b < 5; b++)
            for (int s = 0; s < 4; s++) cycle(1'b1, (b + 1) * 10, 1'b0, 1'b0);
        vectors++; if (bus.level !== 3'd4) begin miscompares++; $display("FAIL ovf_level: got %0d want 4", bus.level); end
        vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
        for (int b = 0; b < 4; b++) begin
            vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_drain_valid %0d: got %b want 1", b, bus.out_valid); end
            vectors++; if (bus.out_data !== IN_W'((b + 1) * 10)) begin miscompares++; $display("FAIL ovf_drain_data %0d: got %0d want %0d", b, bus.out_data, (b + 1) * 10); end
            cycle(1'b0, 0, 1'b1, 1'b0);
        end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_dropped_absent: valid got %b want 0", bus.out_valid); end
        vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
        cycle(1'b0, 0, 1'b0, 1'b1);
        vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
    endtask

    task automatic test_full_push_pop();
        int want [4] = '{70, 80, 90, 100};
        do_reset();
        for (int b = 0; b < 4; b++)
            for (int s = 0; s < 4; s++) cycle(1'b1, 60 + b * 10, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) cycle(1'b1, 100, 1'b0, 1'b0);
        cycle(1'b1, 100, 1'b1, 1'b0);
        vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL full_pp_ovf: got %b want 0", bus.overflow); end
        vectors++; if (bus.level !== 3'd4) begin miscompares++; $display("FAIL full_pp_level: got %0d want 4", bus.level); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (bus.out_data !== IN_W'(want[k])) begin miscompares++; $display("FAIL full_pp_drain %0d: got %0d want %0d", k, bus.out_data, want[k]); end
            cycle(1'b0, 0, 1'b1, 1'b0);
        end
        vectors++; if (bus.level !== 3'd0) begin miscompares++; $display("FAIL full_pp_empty: got %0d want 0", bus.level); end
    endtask

    task automatic test_reset_mid_block();
        do_reset();
        for (int s = 0; s < 4; s++) cycle(1'b1, 200, 1'b0, 1'b0);
        for (int s = 0; s < 2; s++) cycle(1'b1, 100, 1'b0, 1'b0);
        // Assert reset between edges: outputs must clear without a clock
        #2 rst = 1'b0;
        model_reset();
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.out_data !== '0) begin miscompares++; $display("FAIL mid_rst_data: got %0d want 0", bus.out_data); end
        vectors++; if (bus.level !== '0) begin miscompares++; $display("FAIL mid_rst_level: got %0d want 0", bus.level); end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int s = 0; s < 4; s++) cycle(1'b1, 8, 1'b0, 1'b0);
        vectors++; if (bus.out_data !== 10'd8) begin miscompares++; $display("FAIL mid_rst_result: got %0d want 8", bus.out_data); end
        vectors++; if (bus.level !== 3'd1) begin miscompares++; $display("FAIL mid_rst_count: got %0d want 1", bus.level); end
    endtask

    task automatic test_random();
        bit v;
        bit rdy;
        bit clr;
        int d;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            v   = ($urandom % 4) != 0;
            d   = int'($urandom_range(0, 1023));
            // Alternate phases of light and heavy backpressure
            rdy = ((i / 100) % 2 == 0) ? (($urandom % 4) != 0) : (($urandom % 6) == 0);
            clr = ($urandom % 24) == 0;
            cycle(v, d, rdy, clr);
            vectors++; if (bus.out_valid !== (fifo.size() != 0)) begin miscompares++; $display("FAIL rnd_valid cyc %0d: got %b want %b", i, bus.out_valid, fifo.size() != 0); end
            vectors++; if (bus.level !== LVL_W'(fifo.size())) begin miscompares++; $display("FAIL rnd_level cyc %0d: got %0d want %0d", i, bus.level, fifo.size()); end
            vectors++; if (bus.overflow !== m_ovf) begin miscompares++; $display("FAIL rnd_ovf cyc %0d: got %b want %b", i, bus.overflow, m_ovf); end
            if (fifo.size() != 0) begin
                vectors++; if (bus.out_data !== IN_W'(fifo[0])) begin miscompares++; $display("FAIL rnd_data cyc %0d: got %0d want %0d", i, bus.out_data, fifo[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_gaps();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_block();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
